// File: rtl/gat_pkg.sv
// +--------------------------------------------------------------------+
// | Module : gat_pkg                                                   |
// | Brief  : Shared GAT constants, weight-address width rule and the   |
// |          weight-row fetcher state encoding.                        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package gat_pkg;

  // Default element width and W matrix geometry
  localparam int GAT_DATA_WIDTH      = 8;
  localparam int GAT_NUM_FEATURE_IN  = 1433;
  localparam int GAT_NUM_FEATURE_OUT = 16;

  // Fetcher control states: wait for W to load, then serve forever
  typedef enum logic [0:0] {
    WAIT_W = 1'b0,
    RUN    = 1'b1
  } fetch_state_e;

  // Column-BRAM address width: the BRAMs are sized for ten W-sized banks
  function automatic int mult_weight_addr_w(input int num_feature_in);
    return $clog2(num_feature_in * 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wgt_row_fifo.sv
// +--------------------------------------------------------------------+
// | Module : wgt_row_fifo                                              |
// | Brief  : Small synchronous FIFO holding fetched weight rows; head  |
// |          data reads as zero while empty.                           |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module wgt_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointer wrap that also works for non-power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is legal when a pop frees the slot this cycle
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  // Gate the head so stale entries left after a reset never show up
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because the head is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wgt_row_fetcher.sv
// +--------------------------------------------------------------------+
// | Module : wgt_row_fetcher                                           |
// | Brief  : Turns sparse-H elements into W-row reads across the       |
// |          column BRAMs and returns {row, value, last} in order.     |
// | Config : WGT_FETCH_PERF_CNT_EN adds a 32-bit saturating stall      |
// |          counter output (perf_stall_cnt_o).                        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module wgt_row_fetcher
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH      = GAT_DATA_WIDTH,
  parameter int NUM_FEATURE_IN  = GAT_NUM_FEATURE_IN,
  parameter int NUM_FEATURE_OUT = GAT_NUM_FEATURE_OUT,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                                         clk,
  input  logic                                                         rst_n,
  input  logic                                                         w_rdy_i,
  input  logic                                                         req_vld_i,
  output logic                                                         req_rdy_o,
  input  logic [$clog2(NUM_FEATURE_IN)-1:0]                            req_col_idx_i,
  input  logic [DATA_WIDTH-1:0]                                        req_val_i,
  input  logic                                                         req_last_i,
  output logic [NUM_FEATURE_OUT*mult_weight_addr_w(NUM_FEATURE_IN)-1:0] mult_wgt_addrb_flat_o,
  input  logic [NUM_FEATURE_OUT*DATA_WIDTH-1:0]                        mult_wgt_dout_flat_i,
  output logic                                                         rsp_vld_o,
  input  logic                                                         rsp_rdy_i,
  output logic [NUM_FEATURE_OUT*DATA_WIDTH-1:0]                        rsp_wgt_row_o,
  output logic [DATA_WIDTH-1:0]                                        rsp_val_o,
  output logic                                                         rsp_last_o,
  output logic                                                         err_o
`ifdef WGT_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                                                  perf_stall_cnt_o
`endif
);

  localparam int          COL_IDX_WIDTH      = $clog2(NUM_FEATURE_IN);
  localparam int          MULT_WEIGHT_ADDR_W = mult_weight_addr_w(NUM_FEATURE_IN);
  localparam int          ROW_W              = NUM_FEATURE_OUT * DATA_WIDTH;
  localparam int          FIFO_W             = ROW_W + DATA_WIDTH + 1;
  localparam int          CNT_W              = $clog2(FIFO_DEPTH + 1);
  localparam int          SUM_W              = CNT_W + 1;
  localparam logic [31:0] NFI_U              = 32'(NUM_FEATURE_IN);

  fetch_state_e                  state;
  logic                          accept;
  logic                          idx_oor;
  logic [MULT_WEIGHT_ADDR_W-1:0] addr_d;
  logic [MULT_WEIGHT_ADDR_W-1:0] addr_q;

  logic                          s1_vld;
  logic [DATA_WIDTH-1:0]         s1_val;
  logic                          s1_last;
  logic                          s1_oor;

  logic [ROW_W-1:0]              push_row;
  logic [FIFO_W-1:0]             push_data;
  logic [FIFO_W-1:0]             fifo_head;
  logic                          fifo_empty;
  logic [CNT_W-1:0]              fifo_count;

  // Admit a request only if a FIFO slot is guaranteed for it and for the
  // element already in the BRAM stage; depends on registers only.
  assign req_rdy_o = (state == RUN) &&
                     (({1'b0, fifo_count} + SUM_W'(s1_vld)) <= SUM_W'(FIFO_DEPTH - 1));
  assign accept    = req_vld_i && req_rdy_o;
  assign idx_oor   = (32'(req_col_idx_i) >= NFI_U);

  // Out-of-range rows read address 0; the row is zeroed on the way out
  assign addr_d = !accept ? addr_q :
                  idx_oor ? '0     :
                  {{(MULT_WEIGHT_ADDR_W - COL_IDX_WIDTH){1'b0}}, req_col_idx_i};

  // Every column BRAM reads the same row
  for (genvar c = 0; c < NUM_FEATURE_OUT; c++) begin : g_addr_rep
    assign mult_wgt_addrb_flat_o[c*MULT_WEIGHT_ADDR_W +: MULT_WEIGHT_ADDR_W] = addr_d;
  end

  // Control FSM: hold off until W is loaded, then run until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_W;
    end else begin
      case (state)
        WAIT_W:  if (w_rdy_i) state <= RUN;
        RUN:     state <= RUN;
        default: state <= WAIT_W;
      endcase
    end
  end

  // Held read address and sticky out-of-range flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      err_o  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (accept && idx_oor) err_o <= 1'b1;
    end
  end

  // Side-band stage that travels alongside the 1-cycle BRAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_val  <= '0;
      s1_last <= 1'b0;
      s1_oor  <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_val  <= req_val_i;
        s1_last <= req_last_i;
        s1_oor  <= idx_oor;
      end
    end
  end

  assign push_row  = s1_oor ? '0 : mult_wgt_dout_flat_i;
  assign push_data = {push_row, s1_val, s1_last};

  wgt_row_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_vld),
    .push_data (push_data),
    .pop       (rsp_rdy_i),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_vld_o = !fifo_empty;
  assign {rsp_wgt_row_o, rsp_val_o, rsp_last_o} = fifo_head;

`ifdef WGT_FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  assign perf_stall_cnt_o = stall_cnt;

  // Count RUN cycles where an offered element was refused, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && req_vld_i && !req_rdy_o && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
